hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

- Multicycle sequencer for unsigned multiply (MULTU) and divide (DIVU); owns the architected HI/LO registers.
- Sits beside the ALU and shifter; its HiOut/LoOut feed the result multiplexer that serves MFHI/MFLO.
- Runs one iterative operation at a time: 32 shift-add or restore-subtract steps, then commits HI/LO.
- Raises a stall so the pipeline cannot read stale HI/LO while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; counter sized to log2(WIDTH).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request valid; sampled with Signal
- Signal  in  6  function code: MULTU 6'b011001, DIVU 6'b011011, MFHI 6'b010000, MFLO 6'b010010, MTHI 6'b010001, MTLO 6'b010011
- dataA  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- dataB  in  WIDTH  multiplier / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are committed
- stall  out  1  combinational: busy && Signal is MFHI, MFLO, MTHI, MTLO, MULTU or DIVU
- HiOut  out  WIDTH  architected HI
- LoOut  out  WIDTH  architected LO

## Operation
- States:
  - IDLE: the only state that accepts requests.
  - MUL: 32 iterations.
  - DIV: 32 iterations.
  - Back to IDLE after the final iteration.
- Accept in IDLE only, when start=1.
  - MULTU → MUL; DIVU → DIV.
  - MTHI/MTLO → HiOut/LoOut ← dataA at that edge; no busy, no done.
  - Any other code → no effect.
- Operands are latched at accept; dataA/dataB are ignored afterwards.
- Working register W is 2·WIDTH+1 bits; iteration counter counts 0..31.
- MUL:
  - Init W = {0, 0, dataB}.
  - Each step: if W[0], W[64:32] += multiplicand; then W >>= 1.
  - Result: HI = W[63:32], LO = W[31:0].
- DIV (restoring):
  - Init R = 0, Q = dividend.
  - Each step: {R,Q} <<= 1; T = R − divisor (33-bit); if T ≥ 0 then R = T, Q[0] = 1.
  - Result: LO = Q, HI = R.
- Divide by zero is not special-cased. It runs 32 cycles and yields LO = 0xFFFFFFFF, HI = dividend.
- HiOut/LoOut keep their old values throughout an operation. Both update only at commit.
- start during busy is ignored, not queued. The requester must hold it while stall=1.

## Timing
- Reset values: state IDLE, busy 0, done 0, HiOut 0, LoOut 0, counter 0, W 0.
- Accept at edge t0 → busy=1 after t0.
- Iterations occur at edges t1..t32.
- At t32:
  - final iteration result is written to HiOut/LoOut;
  - done=1 for the cycle t32..t33;
  - busy=0; state IDLE.
- Latency from accept edge to visible result: 32 edges.
- Minimum issue interval: 33 edges; a new start sampled at t33 is accepted.
- MTHI/MTLO latency is 1 edge; the value is visible after the accept edge.
- stall is combinational on busy and Signal. It is low in the done cycle, because busy is already 0, so MFHI then reads the new value.
- Reset mid-operation aborts immediately: HI/LO=0, no done pulse.
- Simultaneous reset and start: reset wins.

## Configuration
- HILO_DIV_EN defined: DIVU is supported as above.
- HILO_DIV_EN undefined:
  - DIV state and the subtract path are not compiled.
  - DIVU with start is a no-op: busy stays 0, no done, HI/LO unchanged.
  - stall is never asserted for DIVU.

## Test plan
- Reset held 2 cycles then released → HiOut=0, LoOut=0, busy=0, done=0, stall=0.
- MULTU dataA=0xFFFFFFFF, dataB=0xFFFFFFFF → busy 32 cycles, done pulse at t32, HiOut=0xFFFFFFFE, LoOut=0x00000001.
- DIVU 100/7 → LoOut=14, HiOut=2. DIVU 0x12345678/0 → LoOut=0xFFFFFFFF, HiOut=0x12345678.
- MULTU 3·5 in flight, then Signal=MFHI at t10 → stall=1 and HiOut still the old value. Also drive start with MULTU 7·7 at t10 → ignored. Final result Lo=15, Hi=0.
- MTHI dataA=0xA5A5A5A5 → HiOut=0xA5A5A5A5 after 1 edge, no done. Then MTLO 0x1 → LoOut=1, HiOut unchanged.
- Reset asserted at t12 of a DIVU → HI/LO=0, busy=0, no done. Next MULTU 6·9 → Lo=54, Hi=0. Without HILO_DIV_EN, DIVU 100/7 → busy stays 0 and HI/LO unchanged.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULTU/DIVU sequencer owning HI/LO; DIVU compiled only with `define HILO_DIV_EN
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE,
        MUL
`ifdef HILO_DIV_EN
        , DIV
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH:0]   w_q, w_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // W holds {carry, HI-partial, multiplier}; add when the LSB is set, then shift right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_acc, mul_next;
    assign mul_sum  = w_q[2*WIDTH:WIDTH] + {1'b0, opa_q};
    assign mul_acc  = w_q[0] ? {mul_sum, w_q[WIDTH-1:0]} : w_q;
    assign mul_next = mul_acc >> 1;

`ifdef HILO_DIV_EN
    // W holds {R, Q}; the remainder can reach 2*divisor after the shift, so subtract in WIDTH+2 bits
    logic [2*WIDTH:0]   div_sh, div_next;
    logic [WIDTH+1:0]   div_t;
    assign div_sh   = {w_q[2*WIDTH-1:0], 1'b0};
    assign div_t    = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b0, opa_q};
    assign div_next = div_t[WIDTH+1] ? div_sh : {div_t[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
`endif

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign HiOut = hi_q;
    assign LoOut = lo_q;
    assign stall = busy && (Signal == F_MFHI || Signal == F_MFLO || Signal == F_MTHI ||
                            Signal == F_MTLO || Signal == F_MULTU
`ifdef HILO_DIV_EN
                            || Signal == F_DIVU
`endif
                            );

    // Next state: accept requests in IDLE, iterate, commit HI/LO on the last step
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (Signal == F_MULTU) begin
                        state_d = MUL;
                        w_d     = {{(WIDTH+1){1'b0}}, dataB};
                        opa_d   = dataA;
                        cnt_d   = '0;
                    end
`ifdef HILO_DIV_EN
                    else if (Signal == F_DIVU) begin
                        state_d = DIV;
                        w_d     = {{(WIDTH+1){1'b0}}, dataA};
                        opa_d   = dataB;
                        cnt_d   = '0;
                    end
`endif
                    else if (Signal == F_MTHI) hi_d = dataA;
                    else if (Signal == F_MTLO) lo_d = dataA;
                end
            end
            MUL: begin
                w_d   = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = IDLE;
                    hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    lo_d    = mul_next[WIDTH-1:0];
                    done_d  = 1'b1;
                end
            end
`ifdef HILO_DIV_EN
            DIV: begin
                w_d   = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = IDLE;
                    hi_d    = div_next[2*WIDTH-1:WIDTH];
                    lo_d    = div_next[WIDTH-1:0];
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            opa_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: table-driven and directed checks of the HI/LO multiply/divide sequencer
module tb_hilo_muldiv_ctrl;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef HILO_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  Signal = 6'd0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic        busy, done, stall;
    logic [31:0] HiOut, LoOut;

    int errors = 0;
    int checks = 0;
    logic [31:0] mh = '0;
    logic [31:0] ml = '0;

    typedef struct {
        logic [5:0]  sig;
        logic [31:0] a;
        logic [31:0] b;
        bit          multi;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[8];

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .stall(stall), .HiOut(HiOut), .LoOut(LoOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        bit bad;
        @(negedge clk);
        start = 1'b1; Signal = v.sig; dataA = v.a; dataB = v.b;
        @(posedge clk); #1;
        start = 1'b0; Signal = 6'd0; dataA = $urandom; dataB = $urandom;
        if (v.multi) begin
            chk($sformatf("v%0d busy_after_accept", idx), {31'd0, busy}, 32'd1);
            bad = 1'b0;
            for (int k = 1; k < 32; k++) begin
                @(posedge clk); #1;
                if (!busy || done || HiOut !== mh || LoOut !== ml) bad = 1'b1;
            end
            chk($sformatf("v%0d inflight_hold", idx), {31'd0, bad}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d done_t32", idx), {31'd0, done}, 32'd1);
            chk($sformatf("v%0d busy_t32", idx), {31'd0, busy}, 32'd0);
        end else begin
            chk($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd0);
            bad = 1'b0;
            for (int k = 0; k < 33; k++) begin
                if (busy || done) bad = 1'b1;
                @(posedge clk); #1;
            end
            chk($sformatf("v%0d no_done", idx), {31'd0, bad}, 32'd0);
        end
        chk($sformatf("v%0d hi", idx), HiOut, v.hi);
        chk($sformatf("v%0d lo", idx), LoOut, v.lo);
        mh = v.hi; ml = v.lo;
    endtask

    initial begin
        bit bad;
        vecs[0] = '{F_MTHI,  32'hA5A5A5A5, 32'h0, 1'b0, 32'hA5A5A5A5, 32'h0};
        vecs[1] = '{F_MTLO,  32'h00000001, 32'h0, 1'b0, 32'hA5A5A5A5, 32'h1};
        vecs[2] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001};
        vecs[3] = DIV_ON ? '{F_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14}
                         : '{F_DIVU, 32'd100, 32'd7, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[4] = DIV_ON ? '{F_DIVU, 32'h12345678, 32'h0, 1'b1, 32'h12345678, 32'hFFFFFFFF}
                         : '{F_DIVU, 32'h12345678, 32'h0, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[5] = '{F_MULTU, 32'h00010000, 32'h00010000, 1'b1, 32'h1, 32'h0};
        vecs[6] = '{F_MULTU, 32'h12345678, 32'h00000010, 1'b1, 32'h1, 32'h23456780};
        vecs[7] = '{F_MFHI,  32'hDEADBEEF, 32'h0, 1'b0, 32'h1, 32'h23456780};

        Signal = F_MFHI;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_hi", HiOut, 32'h0);
        chk("rst_lo", LoOut, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        Signal = 6'd0;

        for (int i = 0; i < 8; i++) run_op(i, vecs[i]);

        // MULTU 3*5 with MFHI and a second MULTU arriving mid-flight
        @(negedge clk);
        start = 1'b1; Signal = F_MULTU; dataA = 32'd3; dataB = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; Signal = 6'd0;
        repeat (10) @(posedge clk);
        #1 Signal = F_MFHI;
        #1 chk("t10_stall_mfhi", {31'd0, stall}, 32'd1);
        chk("t10_hi_old", HiOut, mh);
        Signal = F_MULTU; start = 1'b1; dataA = 32'd7; dataB = 32'd7;
        #1 chk("t10_stall_multu", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; Signal = F_MFHI;
        chk("t11_busy", {31'd0, busy}, 32'd1);
        repeat (20) @(posedge clk);
        #1 chk("t31_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("t32_done", {31'd0, done}, 32'd1);
        chk("t32_stall_low", {31'd0, stall}, 32'd0);
        chk("t32_lo", LoOut, 32'd15);
        chk("t32_hi", HiOut, 32'd0);
        @(posedge clk); #1;
        chk("t33_done", {31'd0, done}, 32'd0);
        chk("t33_busy", {31'd0, busy}, 32'd0);
        chk("t33_lo", LoOut, 32'd15);
        Signal = 6'd0;
        mh = 32'd0; ml = 32'd15;

        // reset at t12 of a long operation
        @(negedge clk);
        start = 1'b1; Signal = DIV_ON ? F_DIVU : F_MULTU; dataA = 32'd100; dataB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; Signal = 6'd0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_hi", HiOut, 32'h0);
        chk("abort_lo", LoOut, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (done || busy) bad = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_done", {31'd0, bad}, 32'd0);
        mh = 32'd0; ml = 32'd0;
        run_op(8, '{F_MULTU, 32'd6, 32'd9, 1'b1, 32'd0, 32'd54});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
